vdp_vram_arbiter: RTL
=====================

// Module: vdp_vram_arbiter
// PURPOSE
//  Shares the single VRAM CPU-side port between the VGA display fetch pipeline and CPU data-port accesses.
//  Display fetch always has priority. CPU reads/writes queue in a command FIFO.
//  A CPU access issues only in cycles the display cannot touch VRAM: screen idle, or a guard gap after the last display fetch.
// PARAMETERS
//  FIFO_DEPTH  4  CPU command FIFO entries (power of 2, >=2)
//  GUARD       4  quiet cycles after last disp_go before CPU may issue while disp_busy=1 (>=1)
// PORTS
//  clk          in   1   system clock (25 MHz pixel clock)
//  rst          in   1   asynchronous, active-high reset
//  disp_busy    in   1   display inside active fetch line (screenBusy)
//  disp_go      in   1   display drives VRAM this cycle (VRAM_go)
//  cpu_req      in   1   CPU command valid; accepted when cpu_ready=1
//  cpu_we       in   1   1=write, 0=read
//  cpu_addr     in   14  VRAM byte address
//  cpu_wdata    in   8   write data
//  cpu_ready    out  1   FIFO not full
//  cpu_rvalid   out  1   one-cycle pulse, cpu_rdata valid
//  cpu_rdata    out  8   read data (registered, held until next read)
//  vram_disp_sel out 1   1=VRAM address mux owned by display
//  vram_addr    out  14  CPU-side VRAM address
//  vram_wdata   out  8   CPU-side write data
//  vram_we      out  1   VRAM write strobe
//  vram_re      out  1   VRAM read strobe; vram_rdata valid next cycle
//  vram_rdata   in   8   VRAM CPU-port read data (1-cycle latency)
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, quiet_cnt=0, cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, vram_we=vram_re=0, vram_addr/wdata=0, vram_disp_sel=1.
//  - Push when cpu_req&&cpu_ready. No pass-through: a push into an empty FIFO is visible at head next cycle.
//  - quiet_cnt: cleared to 0 on disp_go, else +1, saturating at GUARD.
//  - grant = state==IDLE && !empty && !disp_go && (!disp_busy || quiet_cnt==GUARD).
//  - The vram_* outputs are combinational from FIFO head, gated by grant. They are 0 when grant=0. vram_disp_sel=!grant.
//  - grant pops head same cycle. Write: vram_we=1, state stays IDLE, so back-to-back writes run 1 per cycle.
//  - Read: vram_re=1, IDLE->RD_WAIT. In RD_WAIT, cpu_rdata<=vram_rdata and cpu_rvalid<=1 (pulse next cycle), then ->IDLE.
//  - Read latency: issue cycle N -> cpu_rvalid high in cycle N+2. Max 1 read per 2 cycles.
//  - disp_go in RD_WAIT does not affect capture: RAM output is already latched.
//  - Simultaneous push and pop: allowed whenever cpu_ready=1. Count unchanged. FIFO order strictly preserved (write-then-read same addr returns new data).
//  - Full: cpu_ready=0. A pop in the same cycle does not re-enable ready until the next cycle.
//  - Wrap: read/write pointers are clog2(FIFO_DEPTH)+1 bits. full = MSBs differ and low bits equal.
//  - Reset mid-read: in-flight read dropped, no cpu_rvalid.
// CONFIGURATION
//  VDP_ARB_STATS_EN defined: adds ports stats_clr in 1 and stall_cnt out 16.
//    stall_cnt counts cycles with !empty && !grant, saturating at 16'hFFFF.
//    stats_clr (sync) zeroes it, with priority over increment. Reset 0.
//  Not defined: ports and counter absent. Arbitration is unchanged.
// STRUCTURE
//  Package vdp_arb_pkg:
//    VRAM_AW=14
//    typedef struct packed {logic we; logic [13:0] addr; logic [7:0] wdata;} vram_cmd_t
//    typedef enum logic {IDLE, RD_WAIT} arb_state_t
//  Sub-module vdp_cmd_fifo (vram_cmd_t payload, FIFO_DEPTH, push/pop/full/empty/head).
//  Top holds quiet counter, FSM, grant logic, read capture.
// TESTING
//  1 disp_busy=0: write 0x03F0<-0xA5 then read 0x03F0 -> vram_we 1 cycle, addr 0x03F0, wdata 0xA5; read cpu_rvalid 2 cycles after vram_re with cpu_rdata=0xA5.
//  2 disp_busy=1, disp_go at offsets 1,3 of every 16-cycle tile; CPU write pushed at offset 0 -> vram_we first at offset 8 (quiet_cnt hits 4), never while disp_go=1.
//  3 disp_go held 1, push 4 writes -> cpu_ready=0 after 4th, no strobes; drop disp_go with disp_busy=0 -> 4 vram_we in consecutive cycles, in order.
//  4 disp_busy=0, head valid, disp_go pulses 1 cycle -> that cycle vram_we=0, vram_disp_sel=1, head kept, issued next cycle.
//  5 rst asserted in RD_WAIT -> cpu_rvalid stays 0, cpu_ready=1, all vram_* 0, FIFO empty.
//  6 VDP_ARB_STATS_EN: 10 blocked cycles with pending command -> stall_cnt=10; stats_clr -> 0.

Source files
------------

// File: rtl/vdp_arb_pkg.sv
// vdp_arb_pkg: command and state types shared by the VRAM arbiter and its command FIFO.
package vdp_arb_pkg;
  localparam int VRAM_AW = 14;
  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         wdata;
  } vram_cmd_t;
  typedef enum logic {IDLE, RD_WAIT} arb_state_t;
endpackage

// File: rtl/vdp_cmd_fifo.sv
// vdp_cmd_fifo: CPU command FIFO; head is visible only from the cycle after a push.
module vdp_cmd_fifo
  import vdp_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  vram_cmd_t din,
  output logic      full,
  output logic      empty,
  output vram_cmd_t head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  vram_cmd_t mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  // extra pointer bit tells full from empty when the index bits match
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];
endmodule

// File: rtl/vdp_vram_arbiter.sv
// vdp_vram_arbiter: shares the VRAM CPU port between display fetch (priority) and queued CPU accesses.
// Define VDP_ARB_STATS_EN to add the stats_clr/stall_cnt stall counter.
module vdp_vram_arbiter
  import vdp_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_busy,
  input  logic               disp_go,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_rvalid,
  output logic [7:0]         cpu_rdata,
  output logic               vram_disp_sel,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_re,
  input  logic [7:0]         vram_rdata
`ifdef VDP_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        stall_cnt
`endif
);
  localparam int QW = $clog2(GUARD + 1);
  localparam logic [QW-1:0] QMAX = QW'(GUARD);
  arb_state_t state, state_nxt;
  logic [QW-1:0] quiet_cnt;
  logic full, empty, grant;
  vram_cmd_t head;
  vdp_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_req && cpu_ready),
    .pop   (grant),
    .din   ('{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  assign cpu_ready = !full;
  assign grant = state == IDLE && !empty && !disp_go && (!disp_busy || quiet_cnt == QMAX);
  always_comb begin
    vram_disp_sel = !grant;
    vram_we       = grant && head.we;
    vram_re       = grant && !head.we;
    vram_addr     = grant ? head.addr : '0;
    vram_wdata    = grant ? head.wdata : '0;
    state_nxt     = state == IDLE ? (vram_re ? RD_WAIT : IDLE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) quiet_cnt <= '0;
    else quiet_cnt <= disp_go ? '0 : (quiet_cnt == QMAX ? quiet_cnt : quiet_cnt + 1'b1);
  // RAM data is already latched during RD_WAIT, so display activity cannot disturb the capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      cpu_rvalid <= state == RD_WAIT;
      if (state == RD_WAIT) cpu_rdata <= vram_rdata;
    end
`ifdef VDP_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (stats_clr) stall_cnt <= '0;
    else if (!empty && !grant && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
